// File: rtl/ddr_ring_wr_sched.sv
// DDR ring-buffer write scheduler: allocates 4KB-safe burst addresses, bounds outstanding
// AXI write bursts, turns in-order B responses into descriptors and reclaims freed space.
module ddr_ring_wr_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_OUTST  = 8,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_size,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [15:0]           alloc_len,
    output logic                  grant_valid,
    input  logic                  grant_ready,
    output logic [ADDR_WIDTH-1:0] grant_addr,
    output logic [7:0]            grant_awlen,
    output logic                  grant_drop,
    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bready,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [ADDR_WIDTH-1:0] desc_addr,
    output logic [15:0]           desc_len,
    output logic                  desc_err,
    input  logic                  free_valid,
    output logic                  free_ready,
    output logic [ADDR_WIDTH-1:0] used_bytes,
    output logic [15:0]           drop_cnt
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int PTR_W      = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W      = $clog2(MAX_OUTST) + 1;
    localparam logic [ADDR_WIDTH-1:0] PAGE = ADDR_WIDTH'(4096);

    typedef enum logic [1:0] {IDLE, CALC, GRANT} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] ring_base, ring_size, wr_off;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] foot_q, next_off_q;
    logic [ADDR_WIDTH-1:0] rlen, page_off, pad, foot, place, end_off;
    logic                  is_drop, fits, cfg_ok;
    logic                  grant_fire, push, b_fire, free_fire;

    logic [ADDR_WIDTH-1:0] pend_addr [MAX_OUTST];
    logic [15:0]           pend_len  [MAX_OUTST];
    logic [ADDR_WIDTH-1:0] pend_foot [MAX_OUTST];
    logic [PTR_W-1:0]      pend_wp, pend_rp;
    logic [CNT_W-1:0]      pend_cnt;
    logic [ADDR_WIDTH-1:0] free_foot [MAX_OUTST];
    logic [PTR_W-1:0]      free_wp, free_rp;
    logic [CNT_W-1:0]      free_cnt;

    assign cfg_ok     = cfg_load && (used_bytes == '0) && (pend_cnt == '0) && (state == IDLE);
    assign grant_fire = (state == GRANT) && grant_ready;
    assign push       = grant_fire && !grant_drop;
    // The free FIFO can hold only MAX_OUTST entries, so a full one back-pressures B.
    assign m_axi_bready = (pend_cnt != '0) && !desc_valid && (free_cnt != CNT_W'(MAX_OUTST));
    assign b_fire     = m_axi_bvalid && m_axi_bready;
    assign free_ready = (free_cnt != '0);
    assign free_fire  = free_valid && free_ready;

    always_comb begin
        rlen     = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(BEAT_BYTES - 1)) >> BEAT_SHIFT) << BEAT_SHIFT;
        page_off = ADDR_WIDTH'(wr_off[11:0]);
        pad      = '0;
        if (page_off + rlen > PAGE)
            pad = PAGE - page_off;
        foot     = pad + rlen;
        // A page pad that lands exactly on the ring end restarts the burst at the ring base.
        place    = wr_off + pad;
        if (place == ring_size)
            place = '0;
        end_off  = place + rlen;
        is_drop  = (len_q < 16'(MIN_LEN)) || (len_q > 16'(MAX_LEN));
        fits     = (({1'b0, used_bytes} + {1'b0, foot}) <= {1'b0, ring_size})
                   && (pend_cnt < CNT_W'(MAX_OUTST));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (alloc_valid && ring_size != '0) state_nxt = CALC;
            CALC:  if (is_drop || fits)                state_nxt = GRANT;
            GRANT: if (grant_ready)                    state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alloc_ready = (state == IDLE) && (ring_size != '0);
        grant_valid = (state == GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_base   <= '0;
            ring_size   <= '0;
            wr_off      <= '0;
            used_bytes  <= '0;
            drop_cnt    <= '0;
            len_q       <= '0;
            grant_addr  <= '0;
            grant_awlen <= '0;
            grant_drop  <= 1'b0;
            foot_q      <= '0;
            next_off_q  <= '0;
        end else begin
            if (cfg_ok) begin
                ring_base <= cfg_base;
                ring_size <= cfg_size;
                wr_off    <= '0;
            end
            if (alloc_valid && alloc_ready)
                len_q <= alloc_len;
            if (state == CALC) begin
                grant_addr  <= ring_base + place;
                grant_awlen <= 8'((rlen >> BEAT_SHIFT) - 1);
                grant_drop  <= is_drop;
                foot_q      <= foot;
                next_off_q  <= (end_off == ring_size) ? '0 : end_off;
                if (is_drop && drop_cnt != '1)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            if (push)
                wr_off <= next_off_q;
            used_bytes <= used_bytes + (push ? foot_q : '0) - (free_fire ? free_foot[free_rp] : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wp  <= '0;
            pend_rp  <= '0;
            pend_cnt <= '0;
            free_wp  <= '0;
            free_rp  <= '0;
            free_cnt <= '0;
        end else begin
            if (push)      pend_wp <= pend_wp + PTR_W'(1);
            if (b_fire)    pend_rp <= pend_rp + PTR_W'(1);
            if (b_fire)    free_wp <= free_wp + PTR_W'(1);
            if (free_fire) free_rp <= free_rp + PTR_W'(1);
            case ({push, b_fire})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
            case ({b_fire, free_fire})
                2'b10:   free_cnt <= free_cnt + CNT_W'(1);
                2'b01:   free_cnt <= free_cnt - CNT_W'(1);
                default: free_cnt <= free_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pend_addr[pend_wp] <= grant_addr;
            pend_len[pend_wp]  <= len_q;
            pend_foot[pend_wp] <= foot_q;
        end
        if (b_fire)
            free_foot[free_wp] <= pend_foot[pend_rp];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            desc_valid <= 1'b0;
            desc_addr  <= '0;
            desc_len   <= '0;
            desc_err   <= 1'b0;
        end else if (b_fire) begin
            desc_valid <= 1'b1;
            desc_addr  <= pend_addr[pend_rp];
            desc_len   <= pend_len[pend_rp];
            desc_err   <= (m_axi_bresp != 2'b00);
        end else if (desc_ready) begin
            desc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_ring_wr_sched.sv
// Randomised bench for ddr_ring_wr_sched against a queue-based ring-allocation model.
module tb_ddr_ring_wr_sched;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [31:0] cfg_size = '0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [15:0] alloc_len = '0;
    logic        grant_valid;
    logic        grant_ready = 1'b0;
    logic [31:0] grant_addr;
    logic [7:0]  grant_awlen;
    logic        grant_drop;
    logic        m_axi_bvalid = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bready;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic [31:0] desc_addr;
    logic [15:0] desc_len;
    logic        desc_err;
    logic        free_valid = 1'b0;
    logic        free_ready;
    logic [31:0] used_bytes;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    ddr_ring_wr_sched #(
        .ADDR_WIDTH(32), .DATA_WIDTH(512), .MAX_OUTST(8), .MIN_LEN(64), .MAX_LEN(1500)
    ) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_base(cfg_base), .cfg_size(cfg_size),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_len(alloc_len),
        .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_addr(grant_addr),
        .grant_awlen(grant_awlen), .grant_drop(grant_drop),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
        .desc_len(desc_len), .desc_err(desc_err),
        .free_valid(free_valid), .free_ready(free_ready),
        .used_bytes(used_bytes), .drop_cnt(drop_cnt)
    );

    typedef struct {
        longint unsigned addr;
        int              len;
        int              foot;
    } pkt_t;

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned m_base, m_size, m_off, m_used;
    int              m_drop;
    pkt_t            pend_q[$];
    int              free_q[$];
    bit              allow_cofree;
    logic [1:0]      unblock_resp;
    logic [31:0]     last_addr;
    logic [7:0]      last_awlen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic int rlen_of(input int len);
        return ((len + 63) / 64) * 64;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        cfg_load = 0; alloc_valid = 0; grant_ready = 0; m_axi_bvalid = 0;
        desc_ready = 0; free_valid = 0;
        repeat (2) tick;
        rst = 1'b0;
        m_base = 0; m_size = 0; m_off = 0; m_used = 0; m_drop = 0;
        pend_q.delete();
        free_q.delete();
    endtask

    task automatic do_cfg(input logic [31:0] base, input logic [31:0] size);
        cfg_base = base; cfg_size = size; cfg_load = 1'b1;
        tick;
        cfg_load = 1'b0;
        if (m_used == 0 && pend_q.size() == 0) begin
            m_base = base; m_size = size; m_off = 0;
        end
    endtask

    task automatic do_free;
        chk("free_ready", free_ready, free_q.size() != 0);
        free_valid = 1'b1;
        tick;
        free_valid = 1'b0;
        if (free_q.size() != 0) m_used -= free_q.pop_front();
        chk("used_after_free", used_bytes, m_used);
    endtask

    task automatic do_b(input logic [1:0] resp);
        pkt_t p;
        int   waitc = 0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = resp;
        while (!m_axi_bready && waitc < 20) begin tick; waitc++; end
        chk("bready", m_axi_bready, 1);
        if (!m_axi_bready) begin
            m_axi_bvalid = 1'b0;
            return;
        end
        tick;
        m_axi_bvalid = 1'b0;
        p = pend_q.pop_front();
        free_q.push_back(p.foot);
        chk("desc_valid", desc_valid, 1);
        chk("desc_addr", desc_addr, p.addr);
        chk("desc_len", desc_len, p.len);
        chk("desc_err", desc_err, resp != 2'b00);
        repeat ($urandom_range(0, 2)) begin
            tick;
            chk("desc_hold", desc_valid, 1);
        end
        desc_ready = 1'b1;
        tick;
        desc_ready = 1'b0;
        chk("desc_clear", desc_valid, 0);
    endtask

    task automatic do_alloc(input int len);
        int              rl, pg, pad, foot, waitc, ffoot;
        longint unsigned place, end_off;
        bit              drop, cofree;
        rl   = rlen_of(len);
        pg   = int'(m_off % 4096);
        pad  = (pg + rl > 4096) ? 4096 - pg : 0;
        foot = pad + rl;
        drop = (len < 64) || (len > 1500);
        alloc_valid = 1'b1;
        alloc_len   = 16'(len);
        waitc = 0;
        while (!alloc_ready && waitc < 20) begin tick; waitc++; end
        chk("alloc_ready", alloc_ready, 1);
        tick;
        alloc_valid = 1'b0;
        chk("lat_calc", grant_valid, 0);
        if (drop || (m_used + foot <= m_size && pend_q.size() < 8)) begin
            tick;
            chk("lat_grant", grant_valid, 1);
        end else begin
            repeat (4) begin
                tick;
                chk("stall", grant_valid, 0);
            end
            while (!(m_used + foot <= m_size && pend_q.size() < 8)) begin
                if (free_q.size() != 0) do_free();
                else do_b(unblock_resp);
            end
        end
        waitc = 0;
        while (!grant_valid && waitc < 20) begin tick; waitc++; end
        chk("grant_valid", grant_valid, 1);
        if (!grant_valid) return;
        // Burst goes to the next page if it would cross one; the ring end maps back to base.
        place = m_off + pad;
        if (place == m_size) place = 0;
        chk("grant_drop", grant_drop, drop);
        if (!drop) begin
            chk("grant_addr", grant_addr, m_base + place);
            chk("grant_awlen", grant_awlen, rl / 64 - 1);
        end
        last_addr  = grant_addr;
        last_awlen = grant_awlen;
        cofree = allow_cofree && free_q.size() != 0 && ($urandom % 2 == 1);
        grant_ready = 1'b1;
        if (cofree) free_valid = 1'b1;
        tick;
        grant_ready = 1'b0;
        free_valid  = 1'b0;
        if (drop) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            m_used += foot;
            end_off = place + rl;
            m_off = (end_off == m_size) ? 0 : end_off;
            pend_q.push_back('{m_base + place, len, foot});
        end
        if (cofree) begin
            ffoot = free_q.pop_front();
            m_used -= ffoot;
        end
        chk("grant_done", grant_valid, 0);
        chk("used_bytes", used_bytes, m_used);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic drain;
        while (pend_q.size() > 0 || free_q.size() > 0) begin
            if (free_q.size() > 0) do_free();
            else do_b(2'b00);
        end
    endtask

    int pat [3] = '{1500, 1500, 1024};
    int bad [6] = '{0, 40, 63, 1501, 2000, 65535};
    int edge_len [4] = '{64, 65, 128, 1500};

    initial begin
        int r, waitc;
        allow_cofree = 0;
        unblock_resp = 2'b00;
        do_reset();
        chk("rst_alloc_ready", alloc_ready, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_desc_valid", desc_valid, 0);
        chk("rst_free_ready", free_ready, 0);
        chk("rst_used", used_bytes, 0);
        chk("rst_drop", drop_cnt, 0);

        alloc_valid = 1'b1; alloc_len = 16'd100;
        repeat (3) begin
            tick;
            chk("nocfg_ready", alloc_ready, 0);
            chk("nocfg_grant", grant_valid, 0);
        end
        alloc_valid = 1'b0;

        do_cfg(BASE, 32'h4000);
        chk("cfg_ready", alloc_ready, 1);

        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        repeat (3) begin
            tick;
            chk("proto_bready", m_axi_bready, 0);
            chk("proto_desc", desc_valid, 0);
        end
        m_axi_bvalid = 1'b0;

        do_alloc(100);
        chk("t1_addr", last_addr, 32'h8000_0000);
        chk("t1_awlen", last_awlen, 1);
        chk("t1_used", used_bytes, 128);
        do_b(2'b00);
        do_free();
        do_alloc(1472);
        do_alloc(1472);
        do_alloc(960);
        do_alloc(1500);
        chk("t2_addr", last_addr, 32'h8000_1000);
        chk("t2_awlen", last_awlen, 23);
        chk("t2_used", used_bytes, 32'h1580);
        do_cfg(BASE, 32'h8000);
        do_alloc(40);
        do_alloc(1501);
        chk("t3_drop", drop_cnt, 2);
        chk("t3_used", used_bytes, 32'h1580);
        drain();

        unblock_resp = 2'b10;
        repeat (9) do_alloc(64);
        drain();

        do_reset();
        do_cfg(BASE, 32'h4000);
        unblock_resp = 2'b00;
        for (int i = 0; i < 12; i++) begin
            do_alloc(pat[i % 3]);
            if (i < 8) do_b(2'b00);
        end
        chk("ring_full", used_bytes, 32'h4000);
        do_alloc(64);
        chk("wrap_addr", last_addr, BASE);
        drain();

        allow_cofree = 1;
        for (int i = 0; i < 400; i++) begin
            unblock_resp = 2'($urandom);
            r = $urandom % 10;
            if (r < 5) begin
                case ($urandom % 8)
                    0:       do_alloc(bad[$urandom % 6]);
                    1:       do_alloc(edge_len[$urandom % 4]);
                    default: do_alloc($urandom_range(64, 1500));
                endcase
            end else if (r < 8) begin
                if (pend_q.size() > 0 && free_q.size() < 8) do_b(2'($urandom));
                else do_free();
            end else begin
                do_free();
            end
        end

        alloc_valid = 1'b1; alloc_len = 16'd40;
        waitc = 0;
        while (!alloc_ready && waitc < 20) begin tick; waitc++; end
        tick;
        alloc_valid = 1'b0;
        waitc = 0;
        while (!grant_valid && waitc < 20) begin tick; waitc++; end
        chk("pre_rst_grant", grant_valid, 1);
        rst = 1'b1;
        tick;
        chk("mid_rst_grant", grant_valid, 0);
        chk("mid_rst_drop", grant_drop, 0);
        chk("mid_rst_alloc", alloc_ready, 0);
        chk("mid_rst_bready", m_axi_bready, 0);
        chk("mid_rst_desc", desc_valid, 0);
        chk("mid_rst_free", free_ready, 0);
        chk("mid_rst_used", used_bytes, 0);
        chk("mid_rst_dropcnt", drop_cnt, 0);
        rst = 1'b0;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
